// File: rtl/mem_arb_pkg.sv
// Shared encodings and defaults for the I/D main-memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } arbStateT;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } ownerT;

  localparam int DEF_MEM_LAT      = 4;
  localparam int DEF_STARVE_LIMIT = 3;

endpackage

// File: rtl/mem_arbiter.sv
// Single-port arbiter between the I-cache and D-cache miss paths: one access at a
// time, fixed D priority with a starvation override that forces an I grant.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_LAT      = DEF_MEM_LAT,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [15:0] i_addr,
  output logic        i_done,
  output logic [15:0] i_data_out,
  input  logic        d_req,
  input  logic        d_wr,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_data_in,
  output logic        d_done,
  output logic [15:0] d_data_out,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_data_in,
  output logic        mem_rd,
  output logic        mem_wr,
  input  logic [15:0] mem_data_out,
  output logic        busy
);

  localparam int LAT_W = $clog2(MEM_LAT + 1);
  localparam int STV_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [LAT_W-1:0] LAT_LAST   = LAT_W'(MEM_LAT);
  localparam logic [STV_W-1:0] STARVE_MAX = STV_W'(STARVE_LIMIT);

  arbStateT           stateReg;
  ownerT              ownerReg;
  logic               isWrReg;
  logic [LAT_W-1:0]   latCntReg;
  logic [STV_W-1:0]   starveCntReg;

  logic forceI;
  logic grantD;

  // Once I has watched STARVE_LIMIT D grants go by, it wins the next decision.
  assign forceI = i_req && (starveCntReg == STARVE_MAX);
  assign grantD = d_req && !forceI;

  always_ff @(posedge clk) begin
    if (rst) begin
      stateReg     <= IDLE;
      ownerReg     <= OWN_I;
      isWrReg      <= 1'b0;
      latCntReg    <= '0;
      starveCntReg <= '0;
      i_done       <= 1'b0;
      d_done       <= 1'b0;
      mem_rd       <= 1'b0;
      mem_wr       <= 1'b0;
      busy         <= 1'b0;
      mem_addr     <= '0;
      mem_data_in  <= '0;
      i_data_out   <= '0;
      d_data_out   <= '0;
    end else begin
      mem_rd <= 1'b0;
      mem_wr <= 1'b0;
      i_done <= 1'b0;
      d_done <= 1'b0;

      unique case (stateReg)
        IDLE: begin
          if (i_req || d_req) begin
            ownerReg <= grantD ? OWN_D : OWN_I;
            isWrReg  <= grantD && d_wr;
            // Strobes and address register here so they appear during ISSUE.
            mem_addr <= grantD ? d_addr : i_addr;
            if (grantD) begin
              mem_data_in <= d_data_in;
            end
            mem_rd <= !(grantD && d_wr);
            mem_wr <= grantD && d_wr;
            if (grantD) begin
              if (i_req && (starveCntReg != STARVE_MAX)) begin
                starveCntReg <= starveCntReg + STV_W'(1);
              end
            end else begin
              starveCntReg <= '0;
            end
            busy     <= 1'b1;
            stateReg <= ISSUE;
          end
        end

        ISSUE: begin
          latCntReg <= LAT_W'(1);
          stateReg  <= WAIT;
        end

        WAIT: begin
          if (latCntReg == LAT_LAST) begin
            if (ownerReg == OWN_I) begin
              i_data_out <= mem_data_out;
              i_done     <= 1'b1;
            end else begin
              if (!isWrReg) begin
                d_data_out <= mem_data_out;
              end
              d_done <= 1'b1;
            end
            stateReg <= DONE;
          end else begin
            latCntReg <= latCntReg + LAT_W'(1);
          end
        end

        DONE: begin
          busy     <= 1'b0;
          stateReg <= IDLE;
        end

        default: stateReg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Transaction-level checker for mem_arbiter: directed scenarios, a reset abort,
// randomized traffic against a memory/priority model, and a MEM_LAT=1 instance.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int L     = 4;
  localparam int LIMIT = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        iReq, iDone, dReq, dWr, dDone, memRd, memWr, busy;
  logic [15:0] iAddr, iDataOut, dAddr, dDataIn, dDataOut, memAddr, memDataIn, memDataOut;

  logic        iReq1, iDone1, dReq1, dWr1, dDone1, memRd1, memWr1, busy1;
  logic [15:0] iAddr1, iDataOut1, dAddr1, dDataIn1, dDataOut1, memAddr1, memDataIn1, memDataOut1;

  mem_arbiter #(.MEM_LAT(L), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .i_req(iReq), .i_addr(iAddr), .i_done(iDone), .i_data_out(iDataOut),
    .d_req(dReq), .d_wr(dWr), .d_addr(dAddr), .d_data_in(dDataIn),
    .d_done(dDone), .d_data_out(dDataOut),
    .mem_addr(memAddr), .mem_data_in(memDataIn), .mem_rd(memRd), .mem_wr(memWr),
    .mem_data_out(memDataOut), .busy(busy)
  );

  mem_arbiter #(.MEM_LAT(1), .STARVE_LIMIT(LIMIT)) dut1 (
    .clk(clk), .rst(rst),
    .i_req(iReq1), .i_addr(iAddr1), .i_done(iDone1), .i_data_out(iDataOut1),
    .d_req(dReq1), .d_wr(dWr1), .d_addr(dAddr1), .d_data_in(dDataIn1),
    .d_done(dDone1), .d_data_out(dDataOut1),
    .mem_addr(memAddr1), .mem_data_in(memDataIn1), .mem_rd(memRd1), .mem_wr(memWr1),
    .mem_data_out(memDataOut1), .busy(busy1)
  );

  int tests = 0;
  int fails = 0;

  function automatic logic [15:0] dflt(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5A3C;
  endfunction

  // Behavioural main memory: data for a read appears only in the cycle MEM_LAT
  // after the strobe; every other cycle carries random garbage.
  typedef struct { int due; logic [15:0] data; } rdT;
  rdT rdQ[$];
  logic [15:0] memArr[logic [15:0]];
  int cycle = 0;

  initial forever begin
    @(posedge clk);
    cycle++;
  end

  initial forever begin
    @(negedge clk);
    while (rdQ.size() > 0 && rdQ[0].due < cycle) void'(rdQ.pop_front());
    if (rdQ.size() > 0 && rdQ[0].due == cycle) begin
      memDataOut = rdQ[0].data;
      void'(rdQ.pop_front());
    end else begin
      memDataOut = 16'($urandom);
    end
    if (memRd) rdQ.push_back('{cycle + L, memArr.exists(memAddr) ? memArr[memAddr] : dflt(memAddr)});
    if (memWr) memArr[memAddr] = memDataIn;
  end

  // Reference model state
  logic        iPend, dPend, dWrP;
  logic [15:0] iAddrP, dAddrP, dDataP;
  int          starve;
  logic [15:0] expI, expD;
  logic [15:0] modelMem[logic [15:0]];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic newI(input logic [15:0] a);
    iPend  = 1'b1;
    iAddrP = a;
  endtask

  task automatic newD(input logic w, input logic [15:0] a, input logic [15:0] d);
    dPend  = 1'b1;
    dWrP   = w;
    dAddrP = a;
    dDataP = d;
  endtask

  // Called at a negedge of an IDLE cycle; returns at the negedge of the next IDLE cycle.
  task automatic step(output bit wonD);
    logic [15:0] a, wd, rdExp;
    bit isWr;
    chk("idle_busy", busy, 0);
    chk("i_data_hold", iDataOut, expI);
    chk("d_data_hold", dDataOut, expD);
    iReq = iPend; iAddr = iAddrP;
    dReq = dPend; dWr = dWrP; dAddr = dAddrP; dDataIn = dDataP;
    wonD = dPend && !(iPend && starve == LIMIT);
    if (wonD) begin
      if (iPend && starve < LIMIT) starve++;
    end else begin
      starve = 0;
    end
    a     = wonD ? dAddrP : iAddrP;
    isWr  = wonD && dWrP;
    wd    = dDataP;
    rdExp = modelMem.exists(a) ? modelMem[a] : dflt(a);
    if (isWr) modelMem[a] = wd;
    for (int k = 1; k <= L + 2; k++) begin
      @(negedge clk);
      if (k == 2) begin
        iAddr   = 16'($urandom);
        dAddr   = 16'($urandom);
        dDataIn = 16'($urandom);
      end
      chk("busy", busy, 1);
      chk("mem_rd", memRd, 32'(k == 1 && !isWr));
      chk("mem_wr", memWr, 32'(k == 1 && isWr));
      chk("mem_addr", memAddr, a);
      if (isWr) chk("mem_data_in", memDataIn, wd);
      chk("i_done", iDone, 32'(k == L + 2 && !wonD));
      chk("d_done", dDone, 32'(k == L + 2 && wonD));
      chk("rdwr_excl", 32'(memRd && memWr), 0);
      chk("done_excl", 32'(iDone && dDone), 0);
    end
    if (!wonD) expI = rdExp;
    else if (!isWr) expD = rdExp;
    chk("i_data_out", iDataOut, expI);
    chk("d_data_out", dDataOut, expD);
    if (wonD) begin
      dPend = 1'b0; dReq = 1'b0;
    end else begin
      iPend = 1'b0; iReq = 1'b0;
    end
    iAddr = iAddrP; dAddr = dAddrP; dDataIn = dDataP;
    @(negedge clk);
  endtask

  initial begin
    bit w;
    rst = 1'b1;
    iReq = 0; iAddr = 0; dReq = 0; dWr = 0; dAddr = 0; dDataIn = 0;
    iReq1 = 0; iAddr1 = 0; dReq1 = 0; dWr1 = 0; dAddr1 = 0; dDataIn1 = 0;
    memDataOut1 = 16'hDEAD;
    iPend = 0; dPend = 0; dWrP = 0; iAddrP = 0; dAddrP = 0; dDataP = 0;
    starve = 0; expI = 0; expD = 0;

    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_dones", {iDone, dDone}, 0);
    chk("rst_strobes", {memRd, memWr}, 0);
    chk("rst_mem_addr", memAddr, 0);
    chk("rst_mem_data_in", memDataIn, 0);
    chk("rst_data_outs", {iDataOut, dDataOut}, 0);
    chk("rst1_outs", {busy1, iDone1, dDone1, memRd1, memWr1}, 0);
    chk("rst1_data", {iDataOut1, dDataOut1}, 0);
    chk("rst1_mem", {memAddr1, memDataIn1}, 0);
    rst = 1'b0;

    // Single I read
    memArr[16'h0040] = 16'h1234;
    modelMem[16'h0040] = 16'h1234;
    newI(16'h0040);
    step(w);
    chk("t1_winner", w, 0);
    chk("t1_data", iDataOut, 16'h1234);

    // D write
    newD(1'b1, 16'h0100, 16'hBEEF);
    step(w);
    chk("t2_winner", w, 1);
    chk("t2_mem_written", memArr[16'h0100], 16'hBEEF);

    // Simultaneous requests: D first, then I in the next IDLE window
    newI(16'h0080);
    newD(1'b0, 16'h0100, 16'h0000);
    step(w);
    chk("both_first_d", w, 1);
    chk("both_read_back", dDataOut, 16'hBEEF);
    step(w);
    chk("both_second_i", w, 0);

    // Starvation override
    newI(16'h0500);
    for (int n = 0; n < 4; n++) begin
      if (!dPend) newD(1'b0, 16'h0600 + 16'(n), 16'h0000);
      step(w);
      chk("starve_winner", w, 32'(n < 3));
    end
    chk("starve_cnt_cleared", dut.starveCntReg, 0);
    dPend = 1'b0; dReq = 1'b0;
    if (iPend) step(w);

    // Reset during WAIT abandons the read
    newI(16'h0300);
    iReq = 1'b1; iAddr = 16'h0300;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; iReq = 1'b0; iPend = 1'b0;
    starve = 0; expI = 0; expD = 0;
    chk("abort_busy", busy, 0);
    chk("abort_mem_addr", memAddr, 0);
    chk("abort_i_data", iDataOut, 0);
    for (int k = 0; k < L + 2; k++) begin
      chk("abort_no_done", {iDone, dDone}, 0);
      @(negedge clk);
    end
    newI(16'h0301);
    step(w);
    chk("after_abort_i", w, 0);

    // Randomized traffic
    for (int n = 0; n < 60; n++) begin
      if (!iPend && $urandom_range(0, 1) == 1) newI({12'h0A0, 4'($urandom)});
      if (!dPend && $urandom_range(0, 2) != 0)
        newD(1'($urandom), {12'h0A0, 4'($urandom)}, 16'($urandom));
      if (!iPend && !dPend) newI({12'h0A0, 4'($urandom)});
      step(w);
    end
    while (iPend || dPend) step(w);

    // MEM_LAT=1 instance: D read completes three cycles after the request
    dReq1 = 1'b1; dWr1 = 1'b0; dAddr1 = 16'h0002;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      memDataOut1 = (k == 2) ? 16'h00FF : 16'hDEAD;
      chk("l1_rd", memRd1, 32'(k == 1));
      chk("l1_addr", memAddr1, 16'h0002);
      chk("l1_done", dDone1, 32'(k == 3));
      chk("l1_rdwr_excl", 32'(memRd1 && memWr1), 0);
      chk("l1_done_excl", 32'(iDone1 && dDone1), 0);
    end
    chk("l1_data", dDataOut1, 16'h00FF);
    dReq1 = 1'b0;
    @(negedge clk);
    chk("l1_idle", busy1, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Arbitrates the single unified four-bank main memory between the I-cache miss path and the D-cache miss/writeback path of the 16-bit pipelined processor. Accepts one request at a time and issues a single-cycle rd/wr strobe to memory. It waits the fixed memory latency, then returns data to the winning requester with a one-cycle done pulse. D-side has fixed priority, with an anti-starvation override for the I-side.

Parameters:
MEM_LAT, 4, cycles from mem_rd/mem_wr strobe to valid mem_data_out (≥1)
STARVE_LIMIT, 3, consecutive D grants while i_req pending before I is forced (≥1)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
i_req  in  1  I-cache read request; held until i_done
i_addr  in  16  I-cache read address; stable while i_req
i_done  out  1  one-cycle pulse: I access complete, i_data_out valid
i_data_out  out  16  I read data; holds until next I completion
d_req  in  1  D-cache request; held until d_done
d_wr  in  1  1=write, 0=read; stable while d_req
d_addr  in  16  D address; stable while d_req
d_data_in  in  16  D write data; stable while d_req
d_done  out  1  one-cycle pulse: D access complete
d_data_out  out  16  D read data; updated only on D read completion
mem_addr  out  16  address to memory
mem_data_in  out  16  write data to memory
mem_rd  out  1  memory read strobe, exactly one cycle per read
mem_wr  out  1  memory write strobe, exactly one cycle per write
mem_data_out  in  16  memory read data, valid MEM_LAT cycles after mem_rd
busy  out  1  high in every state except IDLE

Behaviour:
- Reset: state=IDLE; i_done, d_done, mem_rd, mem_wr, busy = 0; mem_addr, mem_data_in, i_data_out, d_data_out = 0; starve_cnt=0; lat_cnt=0.
- Reset mid-access: the in-flight access is abandoned, no done pulse is issued, and outputs go to reset values on the next edge.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE, cycle T, with any request present:
  - Choose owner: if d_req && !(i_req && starve_cnt==STARVE_LIMIT), choose D; else if i_req, choose I.
  - Latch owner, addr, wr flag and write data, then go to ISSUE.
- starve_cnt:
  - Increments (saturating at STARVE_LIMIT) on a D grant while i_req=1.
  - Clears on any I grant.
  - Unchanged otherwise.
- ISSUE (T+1): mem_rd or mem_wr high for this single cycle, with mem_addr/mem_data_in = latched values; lat_cnt loaded with 1; go to WAIT.
- WAIT:
  - lat_cnt increments each cycle.
  - At cycle T+1+MEM_LAT (lat_cnt==MEM_LAT): capture mem_data_out into the owner's data_out (reads only), then go to DONE.
  - Writes also wait the full latency.
- DONE (T+2+MEM_LAT): owner's done=1 for exactly this cycle; go to IDLE.
  - A req still high in IDLE at T+3+MEM_LAT is treated as a new request.
- Request-to-done latency is MEM_LAT+2 cycles; minimum back-to-back spacing is MEM_LAT+3 cycles.
- mem_addr/mem_data_in hold their latched values from ISSUE through DONE and update only on the next ISSUE.
- Requests arriving in ISSUE, WAIT or DONE are not sampled; the requester keeps req high and waits.
- Requests that change address mid-access are ignored; latched values are used.
- i_done and d_done are never high in the same cycle.
- mem_rd and mem_wr are never high together.

Decomposition:
- mem_arb_pkg: state encoding localparams (IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, DONE=2'd3), owner encoding (OWN_I=1'b0, OWN_D=1'b1), default MEM_LAT/STARVE_LIMIT.
- starve_cnt width is $clog2(STARVE_LIMIT+1); lat_cnt width is $clog2(MEM_LAT+1).
- No sub-module: FSM, latency counter and starvation counter sit in one module.

Test Plan:
- Single I read: i_req=1, i_addr=0x0040, mem returns 0x1234 at the 4th cycle after mem_rd → mem_rd pulses at cycle 1; i_done=1 at cycle 6 with i_data_out=0x1234; d_done stays 0.
- D write: d_req=1, d_wr=1, d_addr=0x0100, d_data_in=0xBEEF → mem_wr=1 only at cycle 1 with mem_addr=0x0100, mem_data_in=0xBEEF; d_done at cycle 6; d_data_out unchanged.
- Simultaneous i_req and d_req from IDLE, starve_cnt=0 → D granted first; I granted in the following IDLE window (cycle 7 decision, mem_rd at cycle 8).
- Starvation: i_req held continuously with d_req re-asserted immediately after each d_done → after 3 D grants the 4th grant goes to I; starve_cnt reads 0 afterwards.
- rst asserted during WAIT (cycle 3 of a read) → no done pulse; busy=0 and state IDLE the cycle after rst; a fresh i_req afterwards completes in MEM_LAT+2 cycles.
- MEM_LAT=1 build: a D read at 0x0002 returning 0x00FF → d_done 3 cycles after request; mem_rd and mem_wr never both high; i_done and d_done never both high (assertions).
